// File: rtl/abs_dif_acc.sv
// abs_dif_acc: windowed SAD and max accumulator behind abs_dif.
// Consumes N_SAMPLES differences over valid/ready, then pulses done.
module abs_dif_acc #(
  parameter int N_SAMPLES = 4,
  parameter int DW        = 4,
  parameter int SW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] difIn,
  input  logic          difValid,
  output logic          difReady,
  output logic [SW-1:0] sum,
  output logic [DW-1:0] maxDif,
  output logic          sat,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N_SAMPLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          xfer;
  logic          last;
  logic [SW:0]   add;

  assign difReady = (state == ACC);
  assign xfer     = difReady & difValid;
  assign last     = (count == CW'(N_SAMPLES - 1));
  // one extra bit so the carry-out drives saturation
  assign add      = {1'b0, sum} + {{(SW + 1 - DW){1'b0}}, difIn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sum    <= '0;
      maxDif <= '0;
      sat    <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= ACC;
            busy   <= 1'b1;
            sum    <= '0;
            maxDif <= '0;
            sat    <= 1'b0;
            count  <= '0;
          end
        end
        ACC: begin
          if (xfer) begin
            sum   <= add[SW] ? '1 : add[SW-1:0];
            sat   <= sat | add[SW];
            count <= count + 1'b1;
            if (difIn > maxDif)
              maxDif <= difIn;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abs_dif_acc.sv
// tb_abs_dif_acc: directed checks of abs_dif_acc.
// Two instances share stimulus; the SW=5 one covers saturation.
module tb_abs_dif_acc;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] difIn;
  logic       difValid;

  logic       difReady, sat, busy, done;
  logic [7:0] sum;
  logic [3:0] maxDif;

  logic       s_difReady, s_sat, s_busy, s_done;
  logic [4:0] s_sum;
  logic [3:0] s_maxDif;

  int n_cmp = 0;
  int n_bad = 0;

  abs_dif_acc #(.N_SAMPLES(4), .DW(4), .SW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .difIn(difIn), .difValid(difValid),
    .difReady(difReady), .sum(sum), .maxDif(maxDif),
    .sat(sat), .busy(busy), .done(done)
  );

  abs_dif_acc #(.N_SAMPLES(4), .DW(4), .SW(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .difIn(difIn), .difValid(difValid),
    .difReady(s_difReady), .sum(s_sum), .maxDif(s_maxDif),
    .sat(s_sat), .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // start a window, feed four values, optional stall before the 3rd
  task automatic run_win(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d,
                         input int stall);
    logic [3:0] v [4];
    v = '{a, b, c, d};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rdy_acc", difReady, 1);
    chk("busy_acc", busy, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int s = 0; s < stall; s++) begin
          difValid = 1'b0;
          @(negedge clk);
          chk("rdy_stall", difReady, 1);
          chk("done_stall", done, 0);
        end
      end
      difIn    = v[i];
      difValid = 1'b1;
      @(negedge clk);
      chk("done_xfer", done, (i == 3) ? 1 : 0);
    end
    difValid = 1'b0;
    chk("rdy_done", difReady, 0);
    chk("busy_done", busy, 1);
    @(negedge clk);
    chk("done_clr", done, 0);
    chk("busy_idle", busy, 0);
    chk("rdy_idle", difReady, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    difIn    = '0;
    difValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_max", maxDif, 0);
    chk("rst_sat", sat, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", difReady, 0);
    chk("rst_busy", busy, 0);

    difIn    = 4'd7;
    difValid = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sum", sum, 0);
    chk("idle_rdy", difReady, 0);
    difValid = 1'b0;

    run_win(4'd9, 4'd6, 4'd0, 4'd12, 0);
    chk("nom_sum", sum, 27);
    chk("nom_max", maxDif, 12);
    chk("nom_sat", sat, 0);
    repeat (2) @(negedge clk);
    chk("hold_sum", sum, 27);
    chk("hold_max", maxDif, 12);

    run_win(4'd9, 4'd6, 4'd0, 4'd12, 2);
    chk("stl_sum", sum, 27);
    chk("stl_max", maxDif, 12);

    run_win(4'd15, 4'd15, 4'd15, 4'd15, 0);
    chk("sat_sum", s_sum, 31);
    chk("sat_sat", s_sat, 1);
    chk("sat_max", s_maxDif, 15);
    chk("wide_sum", sum, 60);
    chk("wide_sat", sat, 0);

    run_win(4'd1, 4'd1, 4'd1, 4'd1, 0);
    chk("unsat_sum", s_sum, 4);
    chk("unsat_sat", s_sat, 0);

    // abort mid-window with an async reset pulse
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    difIn    = 4'd9;
    difValid = 1'b1;
    @(negedge clk);
    difIn = 4'd6;
    @(negedge clk);
    difValid = 1'b0;
    chk("mid_sum", sum, 15);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sum", sum, 0);
    chk("arst_max", maxDif, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", difReady, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_nodone", done, 0);
    end
    run_win(4'd3, 4'd3, 4'd3, 4'd3, 0);
    chk("post_sum", sum, 12);
    chk("post_max", maxDif, 3);

    // start held high through DONE
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      difIn    = 4'd2;
      difValid = 1'b1;
      @(negedge clk);
    end
    difValid = 1'b0;
    chk("b2b_done", done, 1);
    chk("b2b_sum", sum, 8);
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_rdy", difReady, 0);
    chk("b2b_hold_sum", sum, 8);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_acc_rdy", difReady, 1);
    chk("b2b_acc_busy", busy, 1);
    chk("b2b_clr_sum", sum, 0);
    for (int i = 1; i <= 4; i++) begin
      difIn    = 4'(i);
      difValid = 1'b1;
      @(negedge clk);
    end
    difValid = 1'b0;
    chk("b2b2_done", done, 1);
    chk("b2b2_sum", sum, 10);
    chk("b2b2_max", maxDif, 4);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/abs_dif_acc.md
Name: abs_dif_acc

Overview:
Sequential consumer placed directly downstream of the combinational abs_dif unit. Accepts a stream of 4-bit absolute differences over a valid/ready handshake and accumulates a fixed-length window. Reports the sum of absolute differences (SAD) and the window maximum, then pulses done. Used for block matching and error-metric experiments in the lab datapath.

Parameters:
N_SAMPLES, 4, number of differences per window (>=1)
DW, 4, width of each difference input (matches abs_dif out)
SW, 8, width of the sum output; saturating

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new window; sampled only in IDLE
difIn  input  DW  absolute difference from abs_dif out
difValid  input  1  difIn valid this cycle
difReady  output  1  block can accept difIn this cycle
sum  output  SW  accumulated SAD, saturating at 2^SW-1
maxDif  output  DW  largest difIn seen in the window
sat  output  1  sum saturated during this window
busy  output  1  high in ACC and DONE states
done  output  1  one-cycle pulse when the window completes

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; sum=0, maxDif=0, sat=0, count=0, done=0, busy=0, difReady=0. Reset asserted mid-window aborts the window. No done pulse is generated.
- The clock and reset are the only timing domain. All outputs are registered except difReady, which is decoded from state (difReady = state==ACC).
- IDLE: difReady=0, busy=0. sum, maxDif and sat hold the previous window's results.
  - start=1 -> ACC next cycle. On that edge: sum=0, maxDif=0, sat=0, count=0.
  - difValid is ignored in IDLE.
- ACC: difReady=1, busy=1. A transfer occurs when difValid && difReady.
  - On each transfer, sum <= min(sum+difIn, 2^SW-1). Compute the addition at SW+1 bits. sat <= sat | carry-out.
  - On each transfer, maxDif <= max(maxDif, difIn); count++.
  - The transfer with count==N_SAMPLES-1 is the last one -> DONE next cycle.
  - Cycles with difValid=0 are stalls; all state holds.
  - start is ignored in ACC.
- DONE: held for exactly one cycle. done=1, busy=1, difReady=0. sum, maxDif and sat are final and stable from this cycle until the next start is accepted. Next state = IDLE unconditionally.
  - start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Latency: done is asserted in the cycle after the N-th transfer. With no stalls, start to done = N_SAMPLES+2 cycles.
- Width rules: difIn is treated as unsigned. The count register width is clog2(N_SAMPLES)+1.
- N_SAMPLES=1: a single transfer moves ACC -> DONE.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then release -> sum=0, maxDif=0, done=0, difReady=0. difValid=1 with difIn=7 while in IDLE -> sum stays 0.
- Nominal window: start, then difIn 9,6,0,12 on consecutive cycles with difValid=1 (|3-12|, |10-4|, |5-5|, |12-0|).
  - Required: done pulses exactly one cycle after the 4th transfer.
  - Required: sum=27, maxDif=12, sat=0; values hold in IDLE afterwards.
- Stalls: same data with difValid=0 inserted for 2 cycles between the 2nd and 3rd values -> same results (sum=27, maxDif=12). done is delayed by exactly 2 cycles; difReady stays 1 throughout ACC.
- Saturation: SW=5, N_SAMPLES=4, difIn 15,15,15,15.
  - Required: sum=31, sat=1, maxDif=15.
  - Required: the next window with 1,1,1,1 gives sum=4, sat=0.
- Reset mid-window: after 2 transfers (9, 6), pulse rst_n low asynchronously between clock edges.
  - Required: outputs clear immediately (sum=0), and done never pulses.
  - Required: a subsequent full window 3,3,3,3 gives sum=12, maxDif=3.
- Back-to-back and ignored start: start held high through the DONE cycle -> the block returns to IDLE. A new window begins only on the next IDLE start sample; sum clears at that edge, not earlier.
